phase_down_timer: RTL and testbench
===================================

// Module: phase_down_timer
// PURPOSE
//  Loadable down-counting phase timer and phase sequencer for the traffic-light controller.
//  Holds the current light phase and loads that phase's duration into Q.
//  Decrements Q on each Count tick and advances to the next phase when Q reaches 0.
//  Sits between the tick source (Count) and the lamp drivers (NS/EW).
// PARAMETERS
//  WIDTH     4  width of remaining-time register Q
//  T_GREEN   9  green load value; green lasts T_GREEN+1 ticks
//  T_YELLOW  2  yellow load value; yellow lasts T_YELLOW+1 ticks
//  T_RED     1  all-red clearance load value; lasts T_RED+1 ticks
// PORTS
//  Clk        in   1      single clock; all state updates on rising edge
//  Clear      in   1      synchronous, active-high reset
//  Count      in   1      tick enable; 0 = hold all state
//  PedReq     in   1      pedestrian request (PED_REQ_EN only; otherwise ignored)
//  Q          out  WIDTH  remaining ticks in phase; Q[0] = MSB
//  NS         out  3      north-south lamps {R,Y,G}, one-hot
//  EW         out  3      east-west lamps {R,Y,G}, one-hot
//  PhaseDone  out  1      1-cycle pulse on the edge that changes phase
// BEHAVIOUR
//  Phase order: NS_GREEN -> NS_YELLOW -> RED_A -> EW_GREEN -> EW_YELLOW -> RED_B -> NS_GREEN.
//  Reset (Clear=1 at edge): phase=NS_GREEN; Q=T_GREEN; NS=G; EW=R; PhaseDone=0; ped latch=0.
//  Clear has priority over Count and PedReq.
//  Count=1 with Q!=0: Q<=Q-1; phase unchanged; PhaseDone<=0.
//  Count=1 with Q==0: phase<=next; Q<=next phase's load value; PhaseDone<=1.
//  Count=0: Q and phase hold; PhaseDone<=0.
//  Lamps are a registered decode of phase, so they change on the same edge as the phase.
//    NS_* phases: EW=R. EW_* phases: NS=R. RED_A/RED_B: NS=EW=R.
//  Never both directions non-red. Unused phase encodings recover to NS_GREEN, Q=T_GREEN.
//  Width rule: loads are truncated to WIDTH bits; parameters must be <= 2^WIDTH-1.
//  No wrap-around: Q never decrements below 0.
//  Clear mid-phase abandons the phase immediately. No partial-count carry-over.
//  Full cycle with defaults = 10+3+2+10+3+2 = 30 Count ticks.
// CONFIGURATION
//  PED_REQ_EN defined:
//    PedReq is sampled every cycle into a sticky latch; Count is not required.
//    On a Count tick in NS_GREEN/EW_GREEN with latch=1 and Q>1: Q<=1 (green shortened).
//      The phase then ends after 2 more ticks. Otherwise the normal decrement applies.
//    The latch clears on entry to RED_A/RED_B.
//    PedReq=1 in the same cycle as a Clear edge is dropped.
//  PED_REQ_EN undefined: PedReq is unused, no latch is built, and timing is fixed.
// STRUCTURE
//  Package traffic_pkg: phase_t enum (6 states), lamp constants LAMP_R=3'b100,
//    LAMP_Y=3'b010, LAMP_G=3'b001, and next_phase() / load_value() functions.
//  Sub-module down_counter #(WIDTH): synchronous load, decrement enable, zero flag,
//    Clear; sequencer FSM is in this module.
// TESTING
//  Clear=1 then 0, Count=0 x5 -> Q=9, NS=100_001 hold {NS=G,EW=R}, PhaseDone=0 throughout.
//  Count=1 x10 -> Q 9..0; the 10th tick gives NS_YELLOW, Q=2, NS=Y, and one PhaseDone pulse.
//  Count=1 x30 from reset -> returns to NS_GREEN, Q=9, 6 PhaseDone pulses, never both non-red.
//  At Q=5 in EW_GREEN, assert Clear -> next cycle NS_GREEN, Q=9, NS=G, EW=R.
//  PED_REQ_EN: PedReq pulse at Q=7 in NS_GREEN, then Count=1 -> Q=1, then 0, then NS_YELLOW.
//  Count toggling 1/0 every cycle -> phase timing in ticks is identical to continuous Count.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic-light phase timer: phase encoding,
// lamp codes, phase order and per-phase load values.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_A     = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED_B     = 3'd5
  } phase_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      NS_GREEN:  next_phase = NS_YELLOW;
      NS_YELLOW: next_phase = RED_A;
      RED_A:     next_phase = EW_GREEN;
      EW_GREEN:  next_phase = EW_YELLOW;
      EW_YELLOW: next_phase = RED_B;
      default:   next_phase = NS_GREEN;
    endcase
  endfunction

  function automatic int unsigned load_value(input phase_t p, input int unsigned t_green,
                                             input int unsigned t_yellow,
                                             input int unsigned t_red);
    case (p)
      NS_GREEN, EW_GREEN:   load_value = t_green;
      NS_YELLOW, EW_YELLOW: load_value = t_yellow;
      default:              load_value = t_red;
    endcase
  endfunction

  // Only the direction owning the phase may be non-red.
  function automatic logic [2:0] ns_lamp(input phase_t p);
    case (p)
      NS_GREEN:  ns_lamp = LAMP_G;
      NS_YELLOW: ns_lamp = LAMP_Y;
      default:   ns_lamp = LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(input phase_t p);
    case (p)
      EW_GREEN:  ew_lamp = LAMP_G;
      EW_YELLOW: ew_lamp = LAMP_Y;
      default:   ew_lamp = LAMP_R;
    endcase
  endfunction

endpackage

// File: rtl/down_counter.sv
// Loadable down counter with synchronous clear, decrement enable and zero flag.
// Decrement saturates at zero.
module down_counter #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (srst) begin
      q_reg <= RESET_VAL;
    end else if (load) begin
      q_reg <= load_val;
    end else if (dec && (q_reg != '0)) begin
      q_reg <= q_reg - WIDTH'(1);
    end
  end

  assign q    = q_reg;
  assign zero = (q_reg == '0);

endmodule

// File: rtl/phase_down_timer.sv
// Traffic-light phase sequencer with per-phase down timer and registered lamp decode.
// Optional pedestrian green-shortening is built only when PED_REQ_EN is defined.
module phase_down_timer
  import traffic_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int T_GREEN  = 9,
  parameter int T_YELLOW = 2,
  parameter int T_RED    = 1
) (
  input  logic             Clk,
  input  logic             Clear,
  input  logic             Count,
  input  logic             PedReq,
  output logic [0:WIDTH-1] Q,
  output logic [2:0]       NS,
  output logic [2:0]       EW,
  output logic             PhaseDone
);

  localparam logic [WIDTH-1:0] GREEN_VAL = WIDTH'(T_GREEN);

  phase_t           phase_reg, phase_next;
  logic [2:0]       ns_reg, ns_next, ew_reg, ew_next;
  logic             done_reg, done_next;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [WIDTH-1:0] cnt_load_val, cnt_q;
  logic             phase_valid, shorten;

  assign phase_valid = phase_reg inside {NS_GREEN, NS_YELLOW, RED_A, EW_GREEN, EW_YELLOW, RED_B};

`ifdef PED_REQ_EN
  logic ped_reg, ped_next, entering_red;

  assign entering_red = (phase_next != phase_reg) && ((phase_next == RED_A) || (phase_next == RED_B));
  // A request arriving on the very edge that enters all-red is kept for the next green.
  assign ped_next     = entering_red ? PedReq : (ped_reg | PedReq);
  assign shorten      = ped_reg && ((phase_reg == NS_GREEN) || (phase_reg == EW_GREEN))
                        && (cnt_q > WIDTH'(1));

  always_ff @(posedge Clk) begin
    if (Clear) ped_reg <= 1'b0;
    else       ped_reg <= ped_next;
  end
`else
  logic unused_ped_req;
  assign unused_ped_req = PedReq;
  assign shorten        = 1'b0;
`endif

  down_counter #(
    .WIDTH    (WIDTH),
    .RESET_VAL(GREEN_VAL)
  ) u_counter (
    .clk     (Clk),
    .srst    (Clear),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .dec     (cnt_dec),
    .q       (cnt_q),
    .zero    (cnt_zero)
  );

  always_ff @(posedge Clk) begin
    if (Clear) begin
      phase_reg <= NS_GREEN;
      ns_reg    <= LAMP_G;
      ew_reg    <= LAMP_R;
      done_reg  <= 1'b0;
    end else begin
      phase_reg <= phase_next;
      ns_reg    <= ns_next;
      ew_reg    <= ew_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    phase_next   = phase_reg;
    done_next    = 1'b0;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = '0;
    if (!phase_valid) begin
      phase_next   = NS_GREEN;
      cnt_load     = 1'b1;
      cnt_load_val = GREEN_VAL;
    end else if (Count) begin
      if (cnt_zero) begin
        phase_next   = next_phase(phase_reg);
        cnt_load     = 1'b1;
        cnt_load_val = WIDTH'(load_value(phase_next, T_GREEN, T_YELLOW, T_RED));
        done_next    = 1'b1;
      end else if (shorten) begin
        cnt_load     = 1'b1;
        cnt_load_val = WIDTH'(1);
      end else begin
        cnt_dec = 1'b1;
      end
    end
    ns_next = ns_lamp(phase_next);
    ew_next = ew_lamp(phase_next);
  end

  assign Q         = cnt_q;
  assign NS        = ns_reg;
  assign EW        = ew_reg;
  assign PhaseDone = done_reg;

endmodule

// File: tb/tb_phase_down_timer.sv
// Directed + random bench for phase_down_timer with a reference model feeding
// an expected-value queue that is drained one entry per clock.
module tb_phase_down_timer;

  logic       Clk, Clear, Count, PedReq;
  logic [3:0] q_obs;
  logic [2:0] ns_obs, ew_obs;
  logic       done_obs;

  phase_down_timer dut (
    .Clk      (Clk),
    .Clear    (Clear),
    .Count    (Count),
    .PedReq   (PedReq),
    .Q        (q_obs),
    .NS       (ns_obs),
    .EW       (ew_obs),
    .PhaseDone(done_obs)
  );

`ifdef PED_REQ_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  typedef struct {
    logic [3:0] q;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   pulses     = 0;

  int         dur[6]    = '{9, 2, 1, 9, 2, 1};
  logic [2:0] ns_tab[6] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] ew_tab[6] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100};

  int m_ph = 0;
  int m_q  = 9;
  bit m_done = 1'b0;
  bit m_ped  = 1'b0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    compared++;
    assert (got === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic clr, input logic cnt, input logic ped);
    exp_t e;
    int   old_ph;
    bit   shorten;
    Clear  = clr;
    Count  = cnt;
    PedReq = ped;
    if (clr) begin
      m_ph = 0; m_q = 9; m_done = 1'b0; m_ped = 1'b0;
    end else begin
      old_ph  = m_ph;
      shorten = PED && m_ped && (m_ph == 0 || m_ph == 3) && (m_q > 1);
      m_done  = 1'b0;
      if (cnt) begin
        if (m_q == 0) begin
          m_ph = (m_ph + 1) % 6; m_q = dur[m_ph]; m_done = 1'b1;
        end else if (shorten) begin
          m_q = 1;
        end else begin
          m_q = m_q - 1;
        end
      end
      if (PED) begin
        if (m_ph != old_ph && (m_ph == 2 || m_ph == 5)) m_ped = ped;
        else m_ped = m_ped | ped;
      end
    end
    e.q = 4'(m_q); e.ns = ns_tab[m_ph]; e.ew = ew_tab[m_ph]; e.done = m_done;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    check("Q", q_obs, e.q);
    check("NS", {1'b0, ns_obs}, {1'b0, e.ns});
    check("EW", {1'b0, ew_obs}, {1'b0, e.ew});
    check("PhaseDone", {3'b0, done_obs}, {3'b0, e.done});
    check("both_nonred", {3'b0, (ns_obs != 3'b100) && (ew_obs != 3'b100)}, 4'd0);
    if (done_obs) pulses++;
    $display("t=%0t clr=%0b cnt=%0b ped=%0b Q=%0d NS=%b EW=%b done=%0b",
             $time, clr, cnt, ped, q_obs, ns_obs, ew_obs, done_obs);
  endtask

  initial begin
    Clear = 1'b1; Count = 1'b0; PedReq = 1'b0;
    step(1, 0, 0);
    step(1, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0);

    // Full cycle: 30 ticks, 6 phase changes, back to NS green with Q=9.
    pulses = 0;
    for (int i = 0; i < 30; i++) step(0, 1, 0);
    check("full_cycle_pulses", 4'(pulses), 4'd6);
    check("full_cycle_Q", q_obs, 4'd9);
    check("full_cycle_NS", {1'b0, ns_obs}, 4'b0001);

    // Walk into EW green with Q=5, then clear mid-phase.
    for (int i = 0; i < 19; i++) step(0, 1, 0);
    check("ew_green_Q5", q_obs, 4'd5);
    check("ew_green_EW", {1'b0, ew_obs}, 4'b0001);
    step(1, 1, 0);
    check("clear_mid_Q", q_obs, 4'd9);

    // Count toggling: 60 cycles = 30 ticks, still exactly 6 phase changes.
    pulses = 0;
    for (int i = 0; i < 60; i++) step(0, 1'(i % 2 == 0), 0);
    check("toggle_pulses", 4'(pulses), 4'd6);

`ifdef PED_REQ_EN
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 0, 1);
    step(0, 1, 0);
    check("ped_short_Q1", q_obs, 4'd1);
    step(0, 1, 0);
    step(0, 1, 0);
    check("ped_yellow", {1'b0, ns_obs}, 4'b0010);
`endif

    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 9) == 0));

    check("scoreboard_empty", 4'(sb.size()), 4'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
